// File: rtl/mips_image_loader.sv
// mips_image_loader: fills instruction memory, data memory or the register
// file from a framed byte stream, and holds the core stalled while loading.
// Frame: TARGET, COUNT_HI, COUNT_LO, 4*N big-endian data bytes, CHK (XOR of
// all preceding frame bytes).
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   in_data/valid/ready     byte stream (transfer when valid && ready)
//   mem_we/sel/addr/wdata   shared word write port (sel 0 imem, 1 dmem, 2 rf)
//   core_hold               core stall, high until a frame loads successfully
//   load_done               one-cycle pulse on successful frame end
//   load_err                sticky error flag, cleared by the next TARGET
module mips_image_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [1:0]            mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned MEM_LIMIT = 1 << ADDR_WIDTH;
  localparam int unsigned REG_LIMIT = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_FIN, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            target_q, target_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            xor_q, xor_d;
  logic [23:0]           word_q, word_d;

  logic                  in_ready_d, mem_we_d, core_hold_d, load_done_d, load_err_d;
  logic [1:0]            mem_sel_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d;

  logic        accept;
  logic [15:0] count_in;
  logic [31:0] limit;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign count_in  = {cnt_hi_q, in_data};
  assign limit     = (target_q == 2'd2) ? 32'(REG_LIMIT) : 32'(MEM_LIMIT);
  // Word index equals the write address, so the last word is index N-1.
  assign last_word = (32'(addr_q) + 32'd1) == 32'(count_q);

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cnt_hi_d    = cnt_hi_q;
    count_d     = count_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    xor_d       = xor_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    core_hold_d = core_hold;
    load_done_d = 1'b0;
    load_err_d  = load_err;

    case (state_q)
      S_IDLE: if (accept) begin
        target_d    = in_data[1:0];
        xor_d       = in_data;
        core_hold_d = 1'b1;
        load_err_d  = 1'b0;
        if (in_data > 8'd2) begin
          state_d    = S_ERR;
          load_err_d = 1'b1;
        end else begin
          state_d = S_CNT_HI;
        end
      end
      S_CNT_HI: if (accept) begin
        cnt_hi_d = in_data;
        xor_d    = xor_q ^ in_data;
        state_d  = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        xor_d      = xor_q ^ in_data;
        count_d    = count_in;
        byte_cnt_d = 2'd0;
        addr_d     = '0;
        word_d     = '0;
        if (32'(count_in) > limit) begin
          state_d    = S_ERR;
          load_err_d = 1'b1;
        end else if (count_in == 16'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        xor_d      = xor_q ^ in_data;
        word_d     = {word_q[15:0], in_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = target_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = {word_q, in_data};
          addr_d      = addr_q + ADDR_WIDTH'(1);
          if (last_word) state_d = S_CHK;
        end
      end
      S_CHK: if (accept) begin
        if (in_data == xor_q) begin
          state_d     = S_FIN;
          load_done_d = 1'b1;
          core_hold_d = 1'b0;
        end else begin
          state_d    = S_ERR;
          load_err_d = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = !((state_d == S_FIN) || (state_d == S_ERR));
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target_q   <= '0;
      cnt_hi_q   <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_sel    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      target_q   <= target_d;
      cnt_hi_q   <= cnt_hi_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      xor_q      <= xor_d;
      word_q     <= word_d;
      in_ready   <= in_ready_d;
      mem_we     <= mem_we_d;
      mem_sel    <= mem_sel_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      core_hold  <= core_hold_d;
      load_done  <= load_done_d;
      load_err   <= load_err_d;
    end
  end

endmodule

// File: tb/tb_mips_image_loader.sv
// Self-checking bench for mips_image_loader: directed and random frames,
// checked against a frame-level reference model of the loader.
module tb_mips_image_loader;

  localparam int unsigned AW = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [1:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_err;

  mips_image_loader #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  typedef logic [7:0] byte_t;
  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    ready_low;
  wr_t   got_q[$];
  wr_t   exp_q[$];
  byte_t frame[$];
  int    acc_cyc[$];
  bit    exp_done, exp_err;

  always @(posedge clock) cyc <= cyc + 1;

  // Write-port and done-pulse monitor.
  always @(negedge clock) begin
    if (mem_we) got_q.push_back(wr_t'{mem_sel, mem_addr, mem_wdata, cyc});
    if (load_done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic byte_t frame_xor(input int upto);
    byte_t x = 8'h00;
    for (int i = 0; i < upto; i++) x = x ^ frame[i];
    return x;
  endfunction

  // Reference model: decode the frame per the loader's rules.
  task automatic model_frame();
    int t, n, lim, b;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    t = int'(frame[0]);
    if (t > 2) begin exp_err = 1'b1; return; end
    n   = int'({frame[1], frame[2]});
    lim = (t == 2) ? 32 : (1 << AW);
    if (n > lim) begin exp_err = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      b = 3 + 4 * w;
      if (b + 3 < frame.size())
        exp_q.push_back(wr_t'{2'(t), AW'(w),
                        {frame[b], frame[b+1], frame[b+2], frame[b+3]}, 0});
    end
    if (frame.size() > 3 + 4 * n) begin
      if (frame[3 + 4 * n] == frame_xor(3 + 4 * n)) exp_done = 1'b1;
      else                                           exp_err  = 1'b1;
    end
  endtask

  task automatic build(input int t, input int n, input bit good);
    frame.delete();
    frame.push_back(8'(t));
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    frame.push_back(good ? frame_xor(frame.size()) : (frame_xor(frame.size()) ^ 8'h5A));
  endtask

  // Drive every byte of frame[]; optional random valid throttling.
  task automatic send_frame(input bit throttle);
    acc_cyc.delete();
    ready_low = 0;
    for (int i = 0; i < frame.size(); i++) begin
      bit sent = 1'b0;
      int guard = 0;
      while (!sent) begin
        @(negedge clock);
        if (guard > 64) begin
          checks++;
          failures++;
          $error("FAIL send_timeout byte=%0d in_ready=%0b required=1", i, in_ready);
          in_valid = 1'b0;
          return;
        end
        guard++;
        if (throttle && ($urandom_range(0, 2) == 0)) begin
          in_valid = 1'b0;
        end else if (!in_ready) begin
          in_valid = 1'b0;
          ready_low++;
        end else begin
          in_valid = 1'b1;
          in_data  = frame[i];
          acc_cyc.push_back(cyc);
          @(posedge clock);
          #1;
          in_valid = 1'b0;
          sent = 1'b1;
        end
      end
      if (i == 0) begin
        check("hold_after_target", 32'(core_hold), 32'd1);
        check("err_after_target", 32'(load_err), 32'(frame[0] > 8'd2));
      end
    end
  endtask

  task automatic run_frame(input string tag, input bit throttle);
    int base_wr, base_done, k;
    base_wr   = got_q.size();
    base_done = done_cnt;
    model_frame();
    send_frame(throttle);
    // One cycle after the final byte was accepted.
    check({tag, "_done_pulse"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err_rise"},   32'(load_err),  32'(exp_err));
    check({tag, "_hold_end"},   32'(core_hold), 32'(!exp_done));
    check({tag, "_ready_low"},  32'(in_ready),  32'd0);
    repeat (3) @(negedge clock);
    check({tag, "_done_count"}, 32'(done_cnt - base_done), 32'(exp_done));
    check({tag, "_wr_count"},   32'(got_q.size() - base_wr), 32'(exp_q.size()));
    for (int w = 0; w < exp_q.size(); w++) begin
      k = base_wr + w;
      if (k < got_q.size()) begin
        check($sformatf("%s_sel%0d", tag, w),  32'(got_q[k].sel),  32'(exp_q[w].sel));
        check($sformatf("%s_addr%0d", tag, w), 32'(got_q[k].addr), 32'(exp_q[w].addr));
        check($sformatf("%s_data%0d", tag, w), got_q[k].data,      exp_q[w].data);
        check($sformatf("%s_cyc%0d", tag, w),  32'(got_q[k].cyc),
              32'(acc_cyc[3 + 4 * w + 3] + 1));
      end
    end
    check({tag, "_ready_stall"}, 32'(ready_low), 32'd0);
    check({tag, "_err_sticky"},  32'(load_err),  32'(exp_err));
    check({tag, "_hold_after"},  32'(core_hold), 32'(!exp_done));
    check({tag, "_done_clear"},  32'(load_done), 32'd0);
    check({tag, "_ready_back"},  32'(in_ready),  32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_sel"},   32'(mem_sel),   32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
  endtask

  byte_t frame_a[$];
  byte_t saved[$];
  int    base_wr;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("hold_idle_after_reset", 32'(core_hold), 32'd1);

    // Instruction-memory load of two words.
    frame_a = '{8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h8C, 8'h09, 8'h00, 8'h04};
    frame = frame_a;
    frame.push_back(frame_xor(frame.size()));
    run_frame("imem", 1'b0);

    // Same frame with a wrong checksum.
    frame = frame_a;
    frame.push_back(8'h00);
    run_frame("badchk", 1'b0);

    // Illegal target.
    frame = '{8'h03};
    run_frame("badtgt", 1'b0);

    // Register-file oversize count, then the exact limit.
    frame = '{8'h02, 8'h00, 8'h21};
    run_frame("rf33", 1'b0);
    build(2, 32, 1'b1);
    run_frame("rf32", 1'b0);

    // Memory oversize count, then a full-size data image.
    frame = '{8'h00, 8'h04, 8'h01};
    run_frame("mem1025", 1'b0);
    build(1, 1024, 1'b1);
    run_frame("mem1024", 1'b0);

    // Zero-length frame.
    frame = '{8'h01, 8'h00, 8'h00, 8'h01};
    run_frame("zero", 1'b0);

    // Three-word data frame, unthrottled then throttled.
    build(1, 3, 1'b1);
    saved = frame;
    run_frame("dmem_fast", 1'b0);
    frame = saved;
    run_frame("dmem_slow", 1'b1);

    // Random frames.
    for (int r = 0; r < 8; r++) begin
      build(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)),
            $urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
    end

    // Reset after two data bytes, then a clean reload.
    build(0, 3, 1'b1);
    saved = frame;
    frame = '{saved[0], saved[1], saved[2], saved[3], saved[4]};
    send_frame(1'b0);
    @(negedge clock);
    base_wr = got_q.size();
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("midreset_no_write", 32'(got_q.size() - base_wr), 32'd0);
    frame = saved;
    run_frame("after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
